// File: rtl/reg_bank.sv
// Host register file: control bytes, ID, and 32-bit saturating event counters
// read atomically through a snapshot into shadow registers.
module reg_bank #(
    parameter int unsigned N_CTRL   = 16,
    parameter int unsigned N_CNT    = 4,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            reg_addr,
    inout  wire  [7:0]            reg_data,
    input  logic                  reg_wr,
    input  logic [N_CNT-1:0]      cnt_inc,
    output logic [N_CTRL*8-1:0]   ctrl_out,
    output logic [N_CTRL-1:0]     ctrl_wr_strobe
);

    localparam int unsigned CIW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int unsigned KIW = (N_CNT > 1) ? $clog2(N_CNT) : 1;

    localparam logic [7:0] ADDR_SNAP = 8'h10;
    localparam logic [7:0] ADDR_SAT  = 8'h11;
    localparam logic [7:0] ADDR_ID   = 8'h12;
    localparam logic [7:0] ADDR_SHD  = 8'h20;
    localparam logic [7:0] CTRL_END  = 8'(N_CTRL);
    localparam logic [7:0] SHD_END   = 8'(32'h20 + 4 * N_CNT);

    logic [N_CTRL-1:0][7:0] ctrl_q, ctrl_d;
    logic [N_CTRL-1:0]      strobe_q, strobe_d;
    logic [N_CNT-1:0][31:0] cnt_q, cnt_d;
    logic [N_CNT-1:0][31:0] shd_q, shd_d;
    logic [N_CNT-1:0]       sat_q, sat_d;

    logic             wr_en;
    logic             ctrl_hit;
    logic             shd_hit;
    logic             snap;
    logic             snap_clr;
    logic [N_CNT-1:0] sat_clr;
    logic [N_CNT-1:0] sat_set;
    logic             rd_hit;
    logic [7:0]       rd_val;

    assign wr_en    = reg_wr && !reset;
    assign ctrl_hit = reg_addr < CTRL_END;
    assign shd_hit  = (reg_addr >= ADDR_SHD) && (reg_addr < SHD_END);

    assign ctrl_out       = ctrl_q;
    assign ctrl_wr_strobe = strobe_q;

    always_comb begin
        ctrl_d   = ctrl_q;
        strobe_d = '0;
        if (wr_en && ctrl_hit) begin
            ctrl_d[reg_addr[CIW-1:0]]   = reg_data;
            strobe_d[reg_addr[CIW-1:0]] = 1'b1;
        end
    end

    // Shadows capture pre-edge counts; a clearing snapshot discards same-edge events.
    always_comb begin
        snap     = wr_en && (reg_addr == ADDR_SNAP);
        snap_clr = snap && reg_data[0];
        sat_clr  = (wr_en && (reg_addr == ADDR_SAT)) ? reg_data[N_CNT-1:0] : '0;
        shd_d    = snap ? cnt_q : shd_q;
        cnt_d    = cnt_q;
        sat_set  = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (snap_clr) begin
                cnt_d[k] = '0;
            end else if (cnt_inc[k]) begin
                if (&cnt_q[k]) begin
                    sat_set[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 32'd1;
                end
            end
        end
        sat_d = (sat_q & ~sat_clr) | sat_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            strobe_q <= '0;
            cnt_q    <= '0;
            shd_q    <= '0;
            sat_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            shd_q    <= shd_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        if (ctrl_hit) begin
            rd_hit = 1'b1;
            rd_val = ctrl_q[reg_addr[CIW-1:0]];
        end else if (reg_addr == ADDR_SAT) begin
            rd_hit = 1'b1;
            rd_val = 8'(sat_q);
        end else if (reg_addr == ADDR_ID) begin
            rd_hit = 1'b1;
            rd_val = ID_VALUE;
        end else if (shd_hit) begin
            rd_hit = 1'b1;
            rd_val = shd_q[reg_addr[2 +: KIW]][{reg_addr[1:0], 3'b000} +: 8];
        end
    end

    assign reg_data = (!reg_wr && !reset && rd_hit) ? rd_val : 8'bzzzz_zzzz;

endmodule
